// File: rtl/imem_load_ctrl.sv
// Boot/reload sequencer and imem port arbiter: packs a byte stream into words written to imem.
// Optional checksum stage enabled by defining IMEM_LOAD_CHECKSUM_EN.
module imem_load_ctrl #(
    parameter int unsigned       ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              cpu_stall,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err
);

`ifdef IMEM_LOAD_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, DATA, CHK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, DATA, DONE} state_t;
`endif

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       shift_q, shift_d;
    logic [7:0]        nm1_q, nm1_d;
    logic [7:0]        word_idx_q, word_idx_d;
    logic              all_rcvd_q, all_rcvd_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
    logic              load_err_q, load_err_d;
`endif
    logic              accept;

    // Intake stops once the last word is packed so nothing is taken during its write cycle.
    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            HDR:  rx_ready = 1'b1;
            DATA: rx_ready = ~all_rcvd_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
            CHK:  rx_ready = 1'b1;
`endif
            default: rx_ready = 1'b0;
        endcase
    end

    assign accept = rx_valid & rx_ready;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        nm1_d       = nm1_q;
        word_idx_d  = word_idx_q;
        all_rcvd_d  = all_rcvd_q;
        wr_ptr_d    = wr_ptr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
        sum_d       = sum_q;
        load_err_d  = load_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_req) begin
                    state_d    = HDR;
                    byte_cnt_d = 2'd0;
                    word_idx_d = 8'd0;
                    all_rcvd_d = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
                    load_err_d = 1'b0;
`endif
                end
            end
            HDR: begin
                if (accept) begin
                    state_d    = DATA;
                    nm1_d      = rx_data;
                    wr_ptr_d   = BASE_ADDR;
                    byte_cnt_d = 2'd0;
                    word_idx_d = 8'd0;
                    all_rcvd_d = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
                    sum_d      = rx_data;
`endif
                end
            end
            DATA: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    shift_d    = {shift_q[15:0], rx_data};
`ifdef IMEM_LOAD_CHECKSUM_EN
                    sum_d      = sum_q + rx_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = {shift_q, rx_data};
                        word_idx_d  = word_idx_q + 8'd1;
                        if (word_idx_q == nm1_q) begin
                            all_rcvd_d = 1'b1;
                        end
                    end
                end
                // Pointer advances on the edge that closes the write cycle.
                if (mem_we_q) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (all_rcvd_q) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef IMEM_LOAD_CHECKSUM_EN
            CHK: begin
                if (accept) begin
                    state_d = DONE;
                    if ((sum_q + rx_data) != 8'h00) begin
                        load_err_d = 1'b1;
                    end
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            byte_cnt_q  <= 2'd0;
            shift_q     <= 24'd0;
            nm1_q       <= 8'd0;
            word_idx_q  <= 8'd0;
            all_rcvd_q  <= 1'b0;
            wr_ptr_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 32'd0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            sum_q       <= 8'd0;
            load_err_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            nm1_q       <= nm1_d;
            word_idx_q  <= word_idx_d;
            all_rcvd_q  <= all_rcvd_d;
            wr_ptr_q    <= wr_ptr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
            sum_q       <= sum_d;
            load_err_q  <= load_err_d;
`endif
        end
    end

    assign load_busy = (state_q != IDLE);
    assign cpu_stall = load_busy;
    assign load_done = (state_q == DONE);
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_addr  = load_busy ? wr_ptr_q : pc_addr;
`ifdef IMEM_LOAD_CHECKSUM_EN
    assign load_err  = load_err_q;
`else
    assign load_err  = 1'b0;
`endif

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: scoreboard of expected imem writes per DUT instance.
// Instance a uses BASE_ADDR 00, instance b uses BASE_ADDR FE for the wrap case.
module tb_imem_load_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        load_req_a, load_req_b;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  pc_addr;

    logic        rdy_a, we_a, stall_a, busy_a, done_a, err_a;
    logic [7:0]  addr_a;
    logic [31:0] wdata_a;
    logic        rdy_b, we_b, stall_b, busy_b, done_b, err_b;
    logic [7:0]  addr_b;
    logic [31:0] wdata_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int done_cnt_a = 0, done_cyc_a = 0, done_cnt_b = 0, done_cyc_b = 0;
    logic [39:0] exp_a[$];
    logic [39:0] exp_b[$];
    logic [31:0] words[$];
    logic        sel = 1'b0;

    logic cur_ready, cur_busy, cur_stall, cur_done;
    assign cur_ready = sel ? rdy_b : rdy_a;
    assign cur_busy  = sel ? busy_b : busy_a;
    assign cur_stall = sel ? stall_b : stall_a;
    assign cur_done  = sel ? done_b : done_a;

    imem_load_ctrl #(.ADDR_W(8), .BASE_ADDR(8'h00)) dut (
        .clk(clk), .rst(rst), .load_req(load_req_a), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rdy_a), .pc_addr(pc_addr), .mem_addr(addr_a), .mem_wdata(wdata_a),
        .mem_we(we_a), .cpu_stall(stall_a), .load_busy(busy_a), .load_done(done_a),
        .load_err(err_a)
    );

    imem_load_ctrl #(.ADDR_W(8), .BASE_ADDR(8'hFE)) dut_fe (
        .clk(clk), .rst(rst), .load_req(load_req_b), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rdy_b), .pc_addr(pc_addr), .mem_addr(addr_b), .mem_wdata(wdata_b),
        .mem_we(we_b), .cpu_stall(stall_b), .load_busy(busy_b), .load_done(done_b),
        .load_err(err_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every imem write must match the head of the scoreboard.
    always @(negedge clk) begin : monitor
        logic [39:0] e;
        if (!rst) begin
            if (we_a) begin
                checks++;
                if (exp_a.size() == 0) begin
                    errors++;
                    $display("FAIL write_a: unexpected write addr=%h data=%h", addr_a, wdata_a);
                end else begin
                    e = exp_a.pop_front();
                    if ({addr_a, wdata_a} !== e || stall_a !== 1'b1) begin
                        errors++;
                        $display("FAIL write_a: got addr=%h data=%h stall=%b, want addr=%h data=%h stall=1",
                                 addr_a, wdata_a, stall_a, e[39:32], e[31:0]);
                    end
                end
            end
            if (we_b) begin
                checks++;
                if (exp_b.size() == 0) begin
                    errors++;
                    $display("FAIL write_b: unexpected write addr=%h data=%h", addr_b, wdata_b);
                end else begin
                    e = exp_b.pop_front();
                    if ({addr_b, wdata_b} !== e || stall_b !== 1'b1) begin
                        errors++;
                        $display("FAIL write_b: got addr=%h data=%h stall=%b, want addr=%h data=%h stall=1",
                                 addr_b, wdata_b, stall_b, e[39:32], e[31:0]);
                    end
                end
            end
            if (done_a) begin
                done_cnt_a++;
                done_cyc_a = cyc;
            end
            if (done_b) begin
                done_cnt_b++;
                done_cyc_b = cyc;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!cur_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_byte: rx_ready stayed 0 for byte %h, want 1", b);
        end
        @(negedge clk);
        last_acc = cyc;
        rx_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic pulse_req(input bit b);
        if (b) load_req_b = 1'b1; else load_req_a = 1'b1;
        @(negedge clk);
        load_req_a = 1'b0;
        load_req_b = 1'b0;
    endtask

    task automatic do_load(input bit b, input logic [7:0] nm1, input bit gap,
                           input bit mid_req, input bit bad_chk);
        int start;
        int n;
        int exp_done;
        logic [7:0] sum;
        logic [7:0] base;
        logic [7:0] bt;
        logic [31:0] w;
        sel   = b;
        base  = b ? 8'hFE : 8'h00;
        start = b ? done_cnt_b : done_cnt_a;
        @(negedge clk);
        pulse_req(b);
        checks++;
        if (cur_busy !== 1'b1 || cur_stall !== 1'b1) begin
            errors++;
            $display("FAIL load_start: busy=%b stall=%b, want 1 1", cur_busy, cur_stall);
        end
        send_byte(nm1, gap);
        sum = nm1;
        for (int i = 0; i <= int'(nm1); i++) begin
            w = words[i];
            if (b) exp_b.push_back({base + 8'(i), w});
            else   exp_a.push_back({base + 8'(i), w});
            for (int j = 0; j < 4; j++) begin
                bt = w[31 - 8*j -: 8];
                send_byte(bt, gap);
                sum = sum + bt;
            end
            if (mid_req && i == 0) pulse_req(b);
        end
`ifdef IMEM_LOAD_CHECKSUM_EN
        send_byte(bad_chk ? (8'h00 - sum - 8'h01) : (8'h00 - sum), 1'b0);
        exp_done = last_acc;
`else
        exp_done = last_acc + 1;
        if (bad_chk) exp_done = last_acc + 1;
`endif
        n = 0;
        while ((b ? done_cnt_b : done_cnt_a) == start && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL load_done: no pulse seen, want pulse at cycle %0d", exp_done);
        end else if ((b ? done_cyc_b : done_cyc_a) != exp_done) begin
            errors++;
            $display("FAIL load_done_latency: pulse at cycle %0d, want %0d",
                     (b ? done_cyc_b : done_cyc_a), exp_done);
        end
        checks++;
        if (cur_stall !== 1'b0 || cur_busy !== 1'b0 || cur_done !== 1'b0) begin
            errors++;
            $display("FAIL load_end: stall=%b busy=%b done=%b, want 0 0 0",
                     cur_stall, cur_busy, cur_done);
        end
        checks++;
        if ((b ? exp_b.size() : exp_a.size()) != 0) begin
            errors++;
            $display("FAIL load_writes: %0d writes missing, want 0",
                     (b ? exp_b.size() : exp_a.size()));
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({rdy_a, we_a, stall_a, busy_a, done_a, err_a} !== 6'b0 || wdata_a !== 32'h0 ||
            addr_a !== pc_addr) begin
            errors++;
            $display("FAIL %s: rdy=%b we=%b stall=%b busy=%b done=%b err=%b wdata=%h addr=%h, want all 0, addr=%h",
                     name, rdy_a, we_a, stall_a, busy_a, done_a, err_a, wdata_a, addr_a, pc_addr);
        end
        checks++;
        if ({rdy_b, we_b, stall_b, busy_b, done_b, err_b} !== 6'b0 || wdata_b !== 32'h0) begin
            errors++;
            $display("FAIL %s_b: rdy=%b we=%b stall=%b busy=%b done=%b err=%b wdata=%h, want all 0",
                     name, rdy_b, we_b, stall_b, busy_b, done_b, err_b, wdata_b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pc_addr = 8'h12;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("after_reset");
    endtask

    task automatic test_basic();
        words = '{32'hDEADBEEF};
        do_load(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_idle_mux();
        pc_addr = 8'h3C;
        #1;
        checks++;
        if (addr_a !== 8'h3C || we_a !== 1'b0 || addr_b !== 8'h3C) begin
            errors++;
            $display("FAIL idle_mux: addr_a=%h addr_b=%h we=%b, want 3c 3c 0", addr_a, addr_b, we_a);
        end
        words = '{32'h11223344, 32'h55667788};
        do_load(1'b0, 8'h01, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_wrap();
        words = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3};
        do_load(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_toggle();
        words = '{32'hCAFEF00D, 32'h12345678};
        do_load(1'b0, 8'h01, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_load();
        sel = 1'b0;
        pc_addr = 8'h55;
        @(negedge clk);
        pulse_req(1'b0);
        send_byte(8'h03, 1'b0);
        exp_a.push_back({8'h00, 32'h01020304});
        for (int j = 1; j <= 4; j++) send_byte(8'(j), 1'b0);
        exp_a.push_back({8'h01, 32'h05060708});
        for (int j = 5; j <= 8; j++) send_byte(8'(j), 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_mid_load");
        checks++;
        if (exp_a.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_writes: %0d writes missing, want 0", exp_a.size());
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_checksum();
        words = '{32'h01020304};
`ifdef IMEM_LOAD_CHECKSUM_EN
        do_load(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (err_a !== 1'b0) begin
            errors++;
            $display("FAIL checksum_good: load_err=%b, want 0", err_a);
        end
        do_load(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (err_a !== 1'b1) begin
            errors++;
            $display("FAIL checksum_bad: load_err=%b, want 1", err_a);
        end
        pulse_req(1'b0);
        checks++;
        if (err_a !== 1'b0) begin
            errors++;
            $display("FAIL checksum_clear: load_err=%b, want 0", err_a);
        end
        send_byte(8'h00, 1'b0);
        exp_a.push_back({8'h00, 32'h01020304});
        for (int j = 1; j <= 4; j++) send_byte(8'(j), 1'b0);
        send_byte(8'hF6, 1'b0);
        repeat (3) @(negedge clk);
`else
        do_load(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (err_a !== 1'b0) begin
            errors++;
            $display("FAIL checksum_off: load_err=%b, want 0", err_a);
        end
`endif
    endtask

    initial begin
        load_req_a = 1'b0;
        load_req_b = 1'b0;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        test_reset();
        test_basic();
        test_idle_mux();
        test_wrap();
        test_toggle();
        test_reset_mid_load();
        test_checksum();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            errors++;
            $display("FAIL final_scoreboard: %0d/%0d writes outstanding, want 0/0",
                     exp_a.size(), exp_b.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
